// File: rtl/i2c_req_arbiter_if.sv
// i2c_req_arbiter_if: requester-side and I2C-master-side signals of the request arbiter
interface i2c_req_arbiter_if #(
    parameter int NREQ = 4
);
    logic [NREQ-1:0]   i_req;
    logic [NREQ-1:0]   i_rd;
    logic [7*NREQ-1:0] i_addr;
    logic [8*NREQ-1:0] i_wdata;
    logic [NREQ-1:0]   o_gnt;
    logic [NREQ-1:0]   o_done;
    logic [NREQ-1:0]   o_err;
    logic [7:0]        o_rdata;
    logic              o_start;
    logic              o_stop;
    logic              o_read;
    logic [6:0]        o_address;
    logic [7:0]        o_txdata;
    logic              i_busy;
    logic [7:0]        i_rxdata;

    modport slave (
        input  i_req, i_rd, i_addr, i_wdata, i_busy, i_rxdata,
        output o_gnt, o_done, o_err, o_rdata, o_start, o_stop, o_read, o_address, o_txdata
    );

    modport master (
        output i_req, i_rd, i_addr, i_wdata, i_busy, i_rxdata,
        input  o_gnt, o_done, o_err, o_rdata, o_start, o_stop, o_read, o_address, o_txdata
    );
endinterface

// File: rtl/i2c_req_arbiter.sv
// i2c_req_arbiter: round-robin arbiter sequencing one shared I2C master transaction at a time
module i2c_req_arbiter #(
    parameter int NREQ = 4,
    parameter int TMO  = 64
) (
    input logic              i_cclk,
    input logic              i_rst,
    i2c_req_arbiter_if.slave io_bus
);
    localparam int IW = $clog2(NREQ);
    localparam int CW = $clog2(TMO);

    typedef enum logic [2:0] {IDLE, GRANT, LAUNCH, W_ADDR, W_DATA, DONE, ERR} state_t;

    state_t          r_state, w_nxt;
    logic [IW-1:0]   r_ptr, r_owner, w_win, w_off;
    logic [IW:0]     w_sum;
    logic [NREQ-1:0] w_rot, r_gnt, w_done, w_err;
    logic [CW-1:0]   r_cnt;
    logic            r_busy, r_rose, r_start, r_read;
    logic [6:0]      r_address;
    logic [7:0]      r_txdata, r_rdata;
    logic            w_rise, w_fall, w_tmo, w_wait;

    assign w_rise = io_bus.i_busy & ~r_busy;
    assign w_fall = ~io_bus.i_busy & r_busy;
    assign w_tmo  = r_cnt == CW'(TMO - 1);
    assign w_wait = (r_state == W_ADDR) || (r_state == W_DATA);
    assign w_rot  = NREQ'({io_bus.i_req, io_bus.i_req} >> r_ptr);

    // Round-robin pick: lowest set bit of the request vector rotated to start at the pointer
    always_comb begin
        w_off = '0;
        for (int i = NREQ - 1; i >= 0; i--) w_off = w_rot[i] ? IW'(i) : w_off;
        w_sum = (IW+1)'(r_ptr) + (IW+1)'(w_off);
        w_win = (w_sum >= (IW+1)'(NREQ)) ? IW'(w_sum - (IW+1)'(NREQ)) : IW'(w_sum);
    end

    // State register
    always_ff @(posedge i_cclk or posedge i_rst)
        if (i_rst) r_state <= IDLE;
        else       r_state <= w_nxt;

    // Next state and owner pulses; a busy fall in a wait state beats the timeout terminal count
    always_comb begin
        w_nxt  = r_state;
        w_done = (r_state == DONE) ? r_gnt : '0;
        w_err  = (r_state == ERR) ? r_gnt : '0;
        case (r_state)
            IDLE:    w_nxt = |io_bus.i_req ? GRANT : IDLE;
            GRANT:   w_nxt = LAUNCH;
            LAUNCH:  w_nxt = W_ADDR;
            W_ADDR:  w_nxt = (r_rose && w_fall) ? W_DATA : (w_tmo ? ERR : W_ADDR);
            W_DATA:  w_nxt = (r_rose && w_fall) ? DONE : (w_tmo ? ERR : W_DATA);
            default: w_nxt = IDLE;
        endcase
    end

    // Grant, launch strobe, latched request fields, read data, busy edge and timeout tracking
    always_ff @(posedge i_cclk or posedge i_rst)
        if (i_rst) begin
            r_busy    <= 1'b0;
            r_start   <= 1'b1;
            r_cnt     <= '0;
            r_rose    <= 1'b0;
            r_owner   <= '0;
            r_ptr     <= '0;
            r_gnt     <= '0;
            r_read    <= 1'b0;
            r_address <= '0;
            r_txdata  <= '0;
            r_rdata   <= '0;
        end else begin
            r_busy  <= io_bus.i_busy;
            r_start <= r_state != LAUNCH;
            r_cnt   <= (w_nxt != r_state) ? '0 : (w_wait ? r_cnt + 1'b1 : r_cnt);
            r_rose  <= (w_nxt != r_state) ? 1'b0 : (r_rose | (w_wait & w_rise));
            if (r_state == IDLE && w_nxt == GRANT) r_owner <= w_win;
            if (r_state == GRANT) begin
                r_gnt     <= NREQ'(1) << r_owner;
                r_read    <= io_bus.i_rd[r_owner];
                r_address <= 7'(io_bus.i_addr >> (7 * r_owner));
                r_txdata  <= 8'(io_bus.i_wdata >> (8 * r_owner));
            end
            if (r_state == W_DATA && w_nxt == DONE && r_read) r_rdata <= io_bus.i_rxdata;
            if (r_state == DONE || r_state == ERR) begin
                r_gnt <= '0;
                r_ptr <= (r_owner == IW'(NREQ - 1)) ? '0 : r_owner + 1'b1;
            end
        end

    assign io_bus.o_gnt     = r_gnt;
    assign io_bus.o_done    = w_done;
    assign io_bus.o_err     = w_err;
    assign io_bus.o_rdata   = r_rdata;
    assign io_bus.o_start   = r_start;
    assign io_bus.o_stop    = r_start;
    assign io_bus.o_read    = r_read;
    assign io_bus.o_address = r_address;
    assign io_bus.o_txdata  = r_txdata;
endmodule
